// File: rtl/i2c_cmd_sequencer_if.sv
// Command and response handshake bundle between a requester and the I2C command sequencer.
interface i2c_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_slave_addr;
  logic [6:0] cmd_reg_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_rw;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_slave_addr, cmd_reg_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rw, rsp_data, rsp_err
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_slave_addr, cmd_reg_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rw, rsp_data, rsp_err
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Buffers I2C register commands in a FIFO, issues them one at a time to the I2C master,
// and returns one response per command; a watchdog turns a hung transfer into an error.
module i2c_cmd_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  i2c_cmd_sequencer_if.slave          bus,
  output logic                        m_start,
  output logic                        m_read_write,
  output logic [6:0]                  m_slave_addr,
  output logic [6:0]                  m_reg_addr,
  output logic [7:0]                  m_data_in,
  input  logic                        m_busy,
  input  logic                        m_done,
  input  logic [7:0]                  m_data_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WDOG_ZERO = WW'(0);
  localparam logic [WW-1:0] WDOG_ONE  = WW'(1);
  localparam logic [WW-1:0] WDOG_LOAD = WW'(TIMEOUT_CYCLES - 1);

  // Entries and the in-flight command are packed as {rw, slave_addr, reg_addr, wdata}.
  logic [22:0]   mem_q [FIFO_DEPTH];
  logic [22:0]   head_s;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [2:0]    state_q, state_d;
  logic [22:0]   m_cmd_q, m_cmd_d;
  logic [9:0]    rsp_q, rsp_d;
  logic          m_start_q, m_start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          idle_q, idle_d;
  logic          push_s, pop_s;

  // Next-state, FIFO bookkeeping and response capture.
  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    m_cmd_d = m_cmd_q;
    rsp_d   = rsp_q;
    head_s  = mem_q[rptr_q];
    push_s  = bus.cmd_valid & cmd_ready_q;
    pop_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Never start while another user of the master is still active.
        if ((level_q != LVL_ZERO) && !m_busy) begin
          pop_s   = 1'b1;
          m_cmd_d = head_s;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        wdog_d  = WDOG_LOAD;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        // A done in the expiry cycle still counts as success.
        if (m_done) begin
          rsp_d   = {m_cmd_q[22], (m_cmd_q[22] ? m_data_out : 8'h00), 1'b0};
          wdog_d  = WDOG_ZERO;
          state_d = S_RESP;
        end else if (wdog_q == WDOG_ZERO) begin
          rsp_d   = {m_cmd_q[22], 8'h00, 1'b1};
          state_d = S_RESP;
        end else begin
          wdog_d = wdog_q - WDOG_ONE;
          if (m_busy || (state_q == S_WAIT_DONE)) begin
            state_d = S_WAIT_DONE;
          end else begin
            state_d = S_WAIT_BUSY;
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    m_start_d   = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_RESP);
    cmd_ready_d = (level_d != LVL_FULL);
    idle_d      = (level_d == LVL_ZERO) && (state_d == S_IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= PTR_ZERO;
      rptr_q      <= PTR_ZERO;
      level_q     <= LVL_ZERO;
      wdog_q      <= WDOG_ZERO;
      m_cmd_q     <= 23'd0;
      rsp_q       <= 10'd0;
      m_start_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      wdog_q      <= wdog_d;
      m_cmd_q     <= m_cmd_d;
      rsp_q       <= rsp_d;
      m_start_q   <= m_start_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      idle_q      <= idle_d;
    end
  end

  // FIFO storage; emptiness is tracked by the pointers, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= {bus.cmd_rw, bus.cmd_slave_addr, bus.cmd_reg_addr, bus.cmd_wdata};
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rw    = rsp_q[9];
  assign bus.rsp_data  = rsp_q[8:1];
  assign bus.rsp_err   = rsp_q[0];
  assign m_start       = m_start_q;
  assign m_read_write  = m_cmd_q[22];
  assign m_slave_addr  = m_cmd_q[21:15];
  assign m_reg_addr    = m_cmd_q[14:8];
  assign m_data_in     = m_cmd_q[7:0];
  assign fifo_level    = level_q;
  assign idle          = idle_q;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural I2C master that answers reads
// with {1'b0, reg_addr} ^ 8'h04 and can be told to hang.
module tb_i2c_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam int DLY   = 8;
  localparam logic [39:0] RST_VEC = 40'h80_0000_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_busy, m_done;
  logic [7:0] m_data_out;
  logic       m_start, m_read_write;
  logic [6:0] m_slave_addr, m_reg_addr;
  logic [7:0] m_data_in;
  logic [2:0] fifo_level;
  logic       idle;

  i2c_cmd_sequencer_if bus ();

  i2c_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .m_start(m_start), .m_read_write(m_read_write), .m_slave_addr(m_slave_addr),
    .m_reg_addr(m_reg_addr), .m_data_in(m_data_in), .m_busy(m_busy), .m_done(m_done),
    .m_data_out(m_data_out), .fifo_level(fifo_level), .idle(idle)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   start_cnt = 0;
  int   start_cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic model_hang = 1'b0;
  logic model_h;
  logic [7:0] model_rd;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (m_start === 1'b1) begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end

  // Master model: busy one cycle after start, done DLY cycles later (or late, when hanging).
  initial begin
    m_busy = 1'b0; m_done = 1'b0; m_data_out = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (m_start === 1'b1) begin
        model_h  = model_hang;
        model_rd = {1'b0, m_reg_addr} ^ 8'h04;
        @(posedge clk); #1;
        m_busy = 1'b1;
        repeat (model_h ? (TO + 5) : DLY) @(posedge clk);
        #1;
        m_done = 1'b1;
        m_data_out = model_h ? 8'hFF : model_rd;
        @(posedge clk); #1;
        m_done = 1'b0; m_busy = 1'b0; m_data_out = 8'h00;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic rw, input logic [6:0] sa, input logic [6:0] ra, input logic [7:0] wd);
    logic acc = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_rw = rw; bus.cmd_slave_addr = sa;
    bus.cmd_reg_addr = ra; bus.cmd_wdata = wd;
    for (int i = 0; i < 300 && !acc; i++) begin
      acc = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (acc !== 1'b1) $display("FAIL push_accept: got %b expected 1 (reg %h)", acc, ra); else n_pass++;
  endtask

  task automatic wait_rsp(output logic rw, output logic [7:0] d, output logic e, output int seen);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 200) begin tick(); n++; end
    n_checks++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL rsp_timeout: got %b expected 1", bus.rsp_valid); else n_pass++;
    rw = bus.rsp_rw; d = bus.rsp_data; e = bus.rsp_err; seen = cyc;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  function automatic logic [39:0] out_vec();
    return {bus.cmd_ready, bus.rsp_valid, bus.rsp_rw, bus.rsp_data, bus.rsp_err, m_start,
            m_read_write, m_slave_addr, m_reg_addr, m_data_in, fifo_level, idle};
  endfunction

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_checks++;
    if (out_vec() !== RST_VEC) $display("FAIL reset_held: got %h expected %h", out_vec(), RST_VEC); else n_pass++;
    rst = 1'b0; tick();
    n_checks++;
    if (out_vec() !== RST_VEC) $display("FAIL reset_release: got %h expected %h", out_vec(), RST_VEC); else n_pass++;
  endtask

  task automatic test_write();
    int s0 = start_cnt; int bad = 0; int k = 0; int seen;
    logic rw; logic [7:0] d; logic e;
    push_cmd(1'b0, 7'h68, 7'h1B, 8'h5A);
    n_checks++;
    if ({fifo_level, m_start, idle} !== {3'd1, 1'b0, 1'b0})
      $display("FAIL write_queued: got %h expected %h", {fifo_level, m_start, idle}, {3'd1, 1'b0, 1'b0}); else n_pass++;
    tick();
    n_checks++;
    if ({m_start, m_read_write, m_slave_addr, m_reg_addr, m_data_in, fifo_level} !== {1'b1, 1'b0, 7'h68, 7'h1B, 8'h5A, 3'd0})
      $display("FAIL write_issue: got %h expected %h",
               {m_start, m_read_write, m_slave_addr, m_reg_addr, m_data_in, fifo_level},
               {1'b1, 1'b0, 7'h68, 7'h1B, 8'h5A, 3'd0}); else n_pass++;
    while (bus.rsp_valid !== 1'b1 && k < 100) begin
      tick(); k++;
      if ({m_start, m_read_write, m_slave_addr, m_reg_addr, m_data_in} !== {1'b0, 1'b0, 7'h68, 7'h1B, 8'h5A}) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL write_hold: got %0d bad cycles expected 0", bad); else n_pass++;
    n_checks++;
    if (start_cnt - s0 !== 1) $display("FAIL write_starts: got %0d expected 1", start_cnt - s0); else n_pass++;
    n_checks++;
    if (cyc - start_cyc !== DLY + 2) $display("FAIL write_latency: got %0d expected %0d", cyc - start_cyc, DLY + 2); else n_pass++;
    wait_rsp(rw, d, e, seen);
    n_checks++;
    if ({rw, d, e} !== {1'b0, 8'h00, 1'b0}) $display("FAIL write_rsp: got %h expected %h", {rw, d, e}, {1'b0, 8'h00, 1'b0}); else n_pass++;
  endtask

  task automatic test_read();
    logic rw; logic [7:0] d; logic e; int seen;
    push_cmd(1'b1, 7'h68, 7'h75, 8'h00);
    wait_rsp(rw, d, e, seen);
    n_checks++;
    if ({rw, d, e} !== {1'b1, 8'h71, 1'b0}) $display("FAIL read_rsp: got %h expected %h", {rw, d, e}, {1'b1, 8'h71, 1'b0}); else n_pass++;
    n_checks++;
    if ({idle, bus.rsp_valid} !== 2'b10) $display("FAIL read_idle: got %b expected 10", {idle, bus.rsp_valid}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic       c_rw [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0] c_sa [5] = '{7'h68, 7'h68, 7'h50, 7'h50, 7'h23};
    logic [6:0] c_ra [5] = '{7'h10, 7'h20, 7'h30, 7'h40, 7'h7F};
    logic [7:0] c_wd [5] = '{8'h11, 8'h00, 8'h33, 8'h00, 8'h00};
    logic [7:0] x_d  [5] = '{8'h00, 8'h24, 8'h00, 8'h44, 8'h7B};
    logic [2:0] x_lv [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic rw; logic [7:0] d; logic e; int seen; int prev = 0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(c_rw[i], c_sa[i], c_ra[i], c_wd[i]);
      n_checks++;
      if (fifo_level !== x_lv[i]) $display("FAIL b2b_level%0d: got %0d expected %0d", i, fifo_level, x_lv[i]); else n_pass++;
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b expected 0", bus.cmd_ready); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(rw, d, e, seen);
      n_checks++;
      if ({rw, d, e} !== {c_rw[i], x_d[i], 1'b0})
        $display("FAIL b2b_rsp%0d: got %h expected %h", i, {rw, d, e}, {c_rw[i], x_d[i], 1'b0}); else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (seen - prev !== DLY + 4) $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, seen - prev, DLY + 4); else n_pass++;
      end
      prev = seen;
    end
  endtask

  task automatic test_timeout();
    logic rw; logic [7:0] d; logic e; int seen; int s; int bad = 0;
    model_hang = 1'b1;
    push_cmd(1'b1, 7'h11, 7'h22, 8'h00);
    tick();
    s = cyc;
    n_checks++;
    if (m_start !== 1'b1) $display("FAIL to_start: got %b expected 1", m_start); else n_pass++;
    wait_rsp(rw, d, e, seen);
    model_hang = 1'b0;
    n_checks++;
    if ({rw, d, e} !== {1'b1, 8'h00, 1'b1}) $display("FAIL to_rsp: got %h expected %h", {rw, d, e}, {1'b1, 8'h00, 1'b1}); else n_pass++;
    n_checks++;
    if (seen - s !== TO + 1) $display("FAIL to_latency: got %0d expected %0d", seen - s, TO + 1); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || m_start !== 1'b0 || idle !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL to_late_done: got %0d bad cycles expected 0", bad); else n_pass++;
    push_cmd(1'b0, 7'h11, 7'h23, 8'h99);
    wait_rsp(rw, d, e, seen);
    n_checks++;
    if ({rw, d, e} !== {1'b0, 8'h00, 1'b0}) $display("FAIL to_next: got %h expected %h", {rw, d, e}, {1'b0, 8'h00, 1'b0}); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic rw; logic [7:0] d; logic e; int seen; int k = 0; int bad = 0; int sc;
    logic [9:0] snap;
    push_cmd(1'b1, 7'h2A, 7'h33, 8'h00);
    push_cmd(1'b0, 7'h2A, 7'h34, 8'h55);
    while (bus.rsp_valid !== 1'b1 && k < 100) begin tick(); k++; end
    snap = {bus.rsp_rw, bus.rsp_data, bus.rsp_err};
    sc = start_cnt;
    n_checks++;
    if (snap !== {1'b1, 8'h37, 1'b0}) $display("FAIL bp_rsp: got %h expected %h", snap, {1'b1, 8'h37, 1'b0}); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b1 || {bus.rsp_rw, bus.rsp_data, bus.rsp_err} !== snap ||
          m_start !== 1'b0 || fifo_level !== 3'd1) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); else n_pass++;
    n_checks++;
    if (start_cnt !== sc) $display("FAIL bp_no_start: got %0d expected %0d", start_cnt, sc); else n_pass++;
    wait_rsp(rw, d, e, seen);
    wait_rsp(rw, d, e, seen);
    n_checks++;
    if ({rw, d, e} !== {1'b0, 8'h00, 1'b0}) $display("FAIL bp_second: got %h expected %h", {rw, d, e}, {1'b0, 8'h00, 1'b0}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic rw; logic [7:0] d; logic e; int seen; int bad = 0;
    push_cmd(1'b0, 7'h3C, 7'h01, 8'hAB);
    repeat (5) tick();
    rst = 1'b1; tick();
    n_checks++;
    if (out_vec() !== RST_VEC) $display("FAIL midrst_outputs: got %h expected %h", out_vec(), RST_VEC); else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || m_start !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL midrst_silent: got %0d bad cycles expected 0", bad); else n_pass++;
    push_cmd(1'b1, 7'h3C, 7'h0E, 8'h00);
    wait_rsp(rw, d, e, seen);
    n_checks++;
    if ({rw, d, e} !== {1'b1, 8'h0A, 1'b0}) $display("FAIL midrst_fresh: got %h expected %h", {rw, d, e}, {1'b1, 8'h0A, 1'b0}); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_slave_addr = 7'h00;
    bus.cmd_reg_addr = 7'h00; bus.cmd_wdata = 8'h00; bus.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench did not complete");
  end
endmodule
